// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the buffered UART transmitter.
package uart_pkg;

    // 24 MHz system clock divided down to 4800 baud.
    localparam int CLK_DIV_DEFAULT = 5000;

    // Bit-times per frame: start + 8 data + stop.
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        WARMUP,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock byte FIFO with first-word-fall-through read data.
// Pointers wrap modulo DEPTH, so DEPTH must be a power of two.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; occupancy is tracked by count, so stale contents are never read as valid.
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_txer_buf.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a frame sequencer.
// After reset the line is held idle for IDLE_BITS bit-times before any frame.
module uart_txer_buf
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int IDLE_BITS = 12,
    parameter int DEPTH     = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] data_in,
    input  logic       en_data_in,
    output logic       TX,
    output logic       full,
    output logic       busy,
    output logic       overflow
);

    localparam int WARM_CYC = CLK_DIV * IDLE_BITS;
    localparam int TIMER_W  = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] WARM_LAST = TIMER_W'(WARM_CYC - 1);

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_next;
    logic [7:0]         shreg;
    logic [7:0]         shreg_next;

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [7:0]         head;
    logic [CNT_W-1:0]   fifo_count;

    // Full is sampled before this cycle's pop, so a write while full is dropped.
    assign push = en_data_in && !full;
    assign busy = (state != IDLE);

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .res     (res),
        .push    (push),
        .pop     (pop),
        .wr_data (data_in),
        .rd_data (head),
        .full    (full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (res) begin
            state   <= WARMUP;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
        end
    end

    // Next-state logic: sequence warmup, then start/data/stop per byte, chaining frames with no gap.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        timer_next = timer + 1'b1;
        bit_next   = bit_idx;
        shreg_next = shreg;
        pop        = 1'b0;

        case (state)
            WARMUP: begin
                if (timer == WARM_LAST) begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            end
            IDLE: begin
                timer_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_next = head;
                    state_next = START;
                end
            end
            START: begin
                if (timer == BIT_LAST) begin
                    timer_next = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_next = '0;
                    shreg_next = {1'b0, shreg[7:1]};
                    bit_next   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (timer == BIT_LAST) begin
                    timer_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shreg_next = head;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = WARMUP;
                timer_next = '0;
            end
        endcase
    end

    // Registered line driver and drop indicator; TX trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            TX       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            overflow <= en_data_in && full;
            case (state)
                START:   TX <= 1'b0;
                DATA:    TX <= shreg[0];
                default: TX <= 1'b1;
            endcase
        end
    end

    // Occupancy can never exceed the FIFO size.
    a_count_bound : assert property (@(posedge clk) disable iff (res) fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_uart_txer_buf.sv
// Directed bench for uart_txer_buf with small bit-time parameters and a loopback receiver model.
module tb_uart_txer_buf;
    import uart_pkg::*;

    localparam int D    = 8;
    localparam int IB   = 12;
    localparam int DP   = 4;
    localparam int WARM = D * IB;

    logic       clk;
    logic       res;
    logic [7:0] data_in;
    logic       en_data_in;
    logic       TX;
    logic       full;
    logic       busy;
    logic       overflow;

    int checks;
    int errors;

    // Receiver model outputs.
    logic [7:0] data_out;
    logic       en_data_out;
    logic [7:0] rx_q [$];
    int         rx_pulses;

    uart_txer_buf #(
        .CLK_DIV   (D),
        .IDLE_BITS (IB),
        .DEPTH     (DP)
    ) dut (
        .clk        (clk),
        .res        (res),
        .data_in    (data_in),
        .en_data_in (en_data_in),
        .TX         (TX),
        .full       (full),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_in    = b;
        en_data_in = 1'b1;
        tick();
        en_data_in = 1'b0;
    endtask

    // Samples one frame starting now; every bit window must be flat for D cycles.
    task automatic capture_frame(input string tag, input logic [7:0] b);
        logic [9:0] seen;
        logic [9:0] exp;
        int         glitches;
        exp      = {1'b1, b, 1'b0};
        seen     = '0;
        glitches = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            seen[i] = TX;
            for (int k = 0; k < D; k++) begin
                if (TX !== seen[i]) glitches++;
                tick();
            end
        end
        check({tag, "_bits"}, 32'(seen), 32'(exp));
        check({tag, "_timing"}, glitches, 0);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_idle_in_time"}, (n < limit) ? 1 : 0, 1);
    endtask

    // Loopback receiver: samples TX mid-bit, emits one en_data_out pulse per byte.
    initial begin
        en_data_out = 1'b0;
        data_out    = '0;
        forever begin
            @(negedge clk);
            if (TX === 1'b0) begin
                repeat (D / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    data_out[i] = TX;
                end
                repeat (D) @(negedge clk);
                rx_q.push_back(data_out);
                en_data_out = 1'b1;
                @(negedge clk);
                en_data_out = 1'b0;
            end
        end
    end

    initial rx_pulses = 0;
    always @(posedge en_data_out) rx_pulses++;

    // Hard stop if the bench itself gets stuck.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp4 [5] = '{8'h3c, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp6 [3] = '{8'h00, 8'hff, 8'haa};

    initial begin
        int         bad;
        int         ovf_seen;
        logic [5:0] full_trace;
        logic [6:0] ovf_trace;
        logic [7:0] got;

        checks     = 0;
        errors     = 0;
        res        = 1'b1;
        en_data_in = 1'b0;
        data_in    = '0;

        // ---- Reset state, then idle warmup with no writes ----
        tick();
        check("rst_tx", TX, 1);
        check("rst_busy", busy, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        res = 1'b0;
        bad = 0;
        for (int i = 1; i < WARM; i++) begin
            tick();
            if (TX !== 1'b1 || busy !== 1'b1) bad++;
        end
        check("warmup_hold", bad, 0);
        tick();
        check("warmup_busy_falls", busy, 0);
        check("warmup_tx_idle", TX, 1);

        // ---- Single byte 8'haa, write-to-start latency of two cycles ----
        write_byte(8'haa);
        check("aa_tx_after_write", TX, 1);
        tick();
        check("aa_tx_after_pop", TX, 1);
        check("aa_busy", busy, 1);
        tick();
        capture_frame("aa", 8'haa);
        check("aa_busy_after", busy, 0);
        check("aa_tx_after", TX, 1);

        // ---- Three back-to-back frames, no idle gap ----
        write_byte(8'h55);
        write_byte(8'h0f);
        write_byte(8'hf0);
        capture_frame("b2b_55", 8'h55);
        capture_frame("b2b_0f", 8'h0f);
        capture_frame("b2b_f0", 8'hf0);
        check("b2b_busy_after", busy, 0);

        // ---- Overflow: 6 writes while transmitting, DEPTH=4 ----
        rx_q.delete();
        write_byte(8'h3c);
        tick();
        full_trace = '0;
        ovf_trace  = '0;
        for (int i = 0; i < 6; i++) begin
            data_in       = 8'h11 * (i + 1);
            en_data_in    = 1'b1;
            tick();
            full_trace[i] = full;
            ovf_trace[i]  = overflow;
        end
        en_data_in   = 1'b0;
        tick();
        ovf_trace[6] = overflow;
        check("ovf_full_trace", 32'(full_trace), 32'b111000);
        check("ovf_pulse_trace", 32'(ovf_trace), 32'b0110000);
        ovf_seen = 0;
        for (int i = 0; i < 7; i++) if (ovf_trace[i]) ovf_seen++;
        check("ovf_pulse_count", ovf_seen, 2);
        wait_idle("ovf", 60 * D);
        repeat (2 * D) tick();
        check("ovf_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("ovf_rx_byte%0d", i), got, exp4[i]);
        end

        // ---- Reset mid-DATA of 8'haa with bytes queued ----
        write_byte(8'haa);
        write_byte(8'h77);
        write_byte(8'h88);
        repeat (5 * D) tick();
        res = 1'b1;
        tick();
        res = 1'b0;
        check("midrst_tx", TX, 1);
        check("midrst_busy", busy, 1);
        check("midrst_full", full, 0);
        bad = 0;
        for (int i = 1; i < WARM; i++) begin
            tick();
            if (TX !== 1'b1 || busy !== 1'b1) bad++;
        end
        check("midrst_warmup_hold", bad, 0);
        tick();
        check("midrst_warmup_end", busy, 0);
        bad = 0;
        for (int i = 0; i < 3 * D; i++) begin
            tick();
            if (TX !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("midrst_fifo_flushed", bad, 0);

        // ---- Loopback into the receiver model ----
        rx_q.delete();
        rx_pulses = 0;
        write_byte(8'h00);
        write_byte(8'hff);
        write_byte(8'haa);
        wait_idle("loop", 40 * D);
        repeat (2 * D) tick();
        check("loop_rx_count", rx_q.size(), 3);
        check("loop_rx_pulses", rx_pulses, 3);
        for (int i = 0; i < 3; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("loop_rx_byte%0d", i), got, exp6[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
